// File: rtl/decode_stage.sv
// ============================================================================
// Module   : decode_stage
// Brief    : RV32I decode stage. It has a 32x32 register file, a load-use
//            stall and a valid/ready bundle register. The optional macro
//            DECODE_WB_BYPASS_EN forwards same-edge write-back data to reads.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PC_in,
    input  logic [31:0] IR_in,
    input  logic        v_in,
    input  logic        flush,
    input  logic        r_in,
    input  logic        ex_load,
    input  logic [4:0]  ex_rd,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        r_out,
    output logic        stall,
    output logic        v_out,
    output logic [31:0] PC_out,
    output logic [31:0] rs1_val,
    output logic [31:0] rs2_val,
    output logic [31:0] imm,
    output logic [4:0]  rd,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic        funct7b5,
    output logic        illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] RESET_PC = 32'hFFFFFFFC;

    function automatic logic [31:0] gen_imm(input logic [31:0] ins);
        logic [31:0] val;
        val = 32'h0;
        case (ins[6:0])
            OP_I, OP_LOAD, OP_JALR: val = {{20{ins[31]}}, ins[31:20]};
            OP_STORE:               val = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            OP_BRANCH:              val = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            OP_LUI, OP_AUIPC:       val = {ins[31:12], 12'b0};
            OP_JAL:                 val = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default:                val = 32'h0;
        endcase
        return val;
    endfunction

    function automatic logic is_illegal(input logic [31:0] ins);
        logic known;
        case (ins[6:0])
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM: known = 1'b1;
            default:                                      known = 1'b0;
        endcase
        return !known || (ins[1:0] != 2'b11);
    endfunction

    logic [31:0] regs [32];

    logic        v_q;
    logic [31:0] pc_q;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [31:0] imm_q;
    logic [4:0]  rd_q;
    logic [6:0]  opcode_q;
    logic [2:0]  funct3_q;
    logic        funct7b5_q;
    logic        illegal_q;

    logic [6:0]  in_opcode;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic        rs1_used;
    logic        rs2_used;
    logic        hazard;
    logic        accept;
    logic [31:0] rs1_rd;
    logic [31:0] rs2_rd;

    assign in_opcode = IR_in[6:0];
    assign rs1_idx   = IR_in[19:15];
    assign rs2_idx   = IR_in[24:20];
    assign rs1_used  = !((in_opcode == OP_LUI) || (in_opcode == OP_AUIPC) || (in_opcode == OP_JAL));
    assign rs2_used  = (in_opcode == OP_R) || (in_opcode == OP_STORE) || (in_opcode == OP_BRANCH);

    // Flush wins over the hazard so a squashed load-use pair never freezes fetch.
    assign hazard = v_in && ex_load && (ex_rd != 5'd0) &&
                    ((rs1_used && (ex_rd == rs1_idx)) || (rs2_used && (ex_rd == rs2_idx)));
    assign stall  = hazard && !flush;
    assign r_out  = (r_in || !v_q) && !stall;
    assign accept = v_in && r_out && !flush;

    always_comb begin
        rs1_rd = (rs1_idx == 5'd0) ? 32'h0 : regs[rs1_idx];
        rs2_rd = (rs2_idx == 5'd0) ? 32'h0 : regs[rs2_idx];
`ifdef DECODE_WB_BYPASS_EN
        if (wb_en && (wb_rd != 5'd0) && (wb_rd == rs1_idx)) rs1_rd = wb_data;
        if (wb_en && (wb_rd != 5'd0) && (wb_rd == rs2_idx)) rs2_rd = wb_data;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (wb_en && (wb_rd != 5'd0)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q        <= 1'b0;
            pc_q       <= RESET_PC;
            rs1_q      <= 32'h0;
            rs2_q      <= 32'h0;
            imm_q      <= 32'h0;
            rd_q       <= NOP_INSTR[11:7];
            opcode_q   <= NOP_INSTR[6:0];
            funct3_q   <= NOP_INSTR[14:12];
            funct7b5_q <= NOP_INSTR[30];
            illegal_q  <= is_illegal(NOP_INSTR);
        end else if (flush) begin
            v_q        <= 1'b0;
            rs1_q      <= 32'h0;
            rs2_q      <= 32'h0;
            imm_q      <= gen_imm(NOP_INSTR);
            rd_q       <= NOP_INSTR[11:7];
            opcode_q   <= NOP_INSTR[6:0];
            funct3_q   <= NOP_INSTR[14:12];
            funct7b5_q <= NOP_INSTR[30];
            illegal_q  <= is_illegal(NOP_INSTR);
        end else if (accept) begin
            v_q        <= 1'b1;
            pc_q       <= PC_in;
            rs1_q      <= rs1_rd;
            rs2_q      <= rs2_rd;
            imm_q      <= gen_imm(IR_in);
            rd_q       <= IR_in[11:7];
            opcode_q   <= in_opcode;
            funct3_q   <= IR_in[14:12];
            funct7b5_q <= IR_in[30];
            illegal_q  <= is_illegal(IR_in);
        end else if (r_in) begin
            v_q <= 1'b0;
        end
    end

    assign v_out    = v_q;
    assign PC_out   = pc_q;
    assign rs1_val  = rs1_q;
    assign rs2_val  = rs2_q;
    assign imm      = imm_q;
    assign rd       = rd_q;
    assign opcode   = opcode_q;
    assign funct3   = funct3_q;
    assign funct7b5 = funct7b5_q;
    assign illegal  = illegal_q;

endmodule

`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter NOP_INSTR, default 32'h00000013, instruction word loaded into IR_q on reset and on flush.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 PC_in  input  32  PC of fetched instruction (fetch PC_out).
REQ-005 IR_in  input  32  fetched instruction word (fetch IR_out).
REQ-006 v_in  input  1  fetch output valid (fetch v_out).
REQ-007 flush  input  1  taken branch/jump resolved in execute (COMP_alu and execute valid).
REQ-008 r_in  input  1  execute ready to accept.
REQ-009 ex_load, ex_rd  input  1, 5  execute stage holds a valid load writing ex_rd.
REQ-010 wb_en, wb_rd, wb_data  input  1, 5, 32  register-file write port.
REQ-011 r_out  output  1  decode can accept (drives fetch r_in).
REQ-012 stall  output  1  load-use hazard, drives fetch stall.
REQ-013 v_out  output  1  decoded bundle valid.
REQ-014 PC_out, rs1_val, rs2_val, imm  output  32 each  decoded bundle.
REQ-015 rd, opcode, funct3, funct7b5, illegal  output  5, 7, 3, 1, 1  decoded fields.

Function
REQ-016 Bundle register SHALL load on a rising edge when v_in and r_out and not flush and not stall; latency exactly one cycle from acceptance to v_out=1.
REQ-017 r_out SHALL equal (r_in or not v_out) and not stall.
REQ-018 Output bundle SHALL hold stable while v_out=1 and r_in=0.
REQ-019 If r_in=1 and no new acceptance occurs, v_out SHALL clear on that edge (bubble).
REQ-020 Register file: 32x32; reads of x0 return 0; writes with wb_rd=0 ignored; write on rising edge when wb_en.
REQ-021 rs1_val/rs2_val SHALL be read from IR_in[19:15]/[24:20] at the acceptance edge.
REQ-022 rs2 is "used" only for opcodes 0110011, 0100011, 1100011; rs1 used for all except 0110111, 0010111, 1101111.
REQ-023 stall SHALL equal v_in and ex_load and ex_rd!=0 and ex_rd matches a used rs field, combinationally, and be forced 0 when flush.
REQ-024 imm: I-type (0010011, 0000011, 1100111) sign-extended [31:20]; S-type [31:25,11:7]; B-type [31,7,30:25,11:8,0]; U-type [31:12,12'b0]; J-type [31,19:12,20,30:21,0]; otherwise 0.
REQ-025 illegal SHALL be 1 for opcode not in {0110011,0010011,0000011,0100011,1100011,1101111,1100111,0110111,0010111,1110011} or IR_in[1:0]!=2'b11; illegal instructions still pass with v_out=1.
REQ-026 flush SHALL clear v_out on the next edge and load NOP_INSTR fields, overriding acceptance, stall and hold.
REQ-027 Simultaneous wb write and read of same register: old value, unless REQ-033.

Reset
REQ-028 While rst_n=0: v_out=0, PC_out=32'hFFFFFFFC, fields decoded from NOP_INSTR, rs1_val=rs2_val=imm=0, all registers 0.
REQ-029 Reset asserted mid-operation SHALL discard the in-flight bundle immediately without waiting for clk.
REQ-030 First acceptance possible on the first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro DECODE_WB_BYPASS_EN controls write-to-read bypass.
REQ-032 Without macro: same-edge read of a register being written returns pre-write contents.
REQ-033 With macro: when wb_en and wb_rd!=0 and wb_rd equals a read index at acceptance, wb_data SHALL be captured instead.

Verification
REQ-034 Reset, then IR_in=32'h00500093 (addi x1,x0,5), v_in=1, r_in=1 -> next cycle v_out=1, rd=1, imm=5, rs1_val=0, opcode=0010011.
REQ-035 ex_load=1, ex_rd=2, IR_in=32'h002081B3 (add x3,x1,x2) -> stall=1, r_out=0, next cycle v_out=0; ex_load=0 -> accepted next edge.
REQ-036 v_out=1, r_in=0 for 3 cycles -> all outputs unchanged; r_in=1 with v_in=0 -> v_out=0 next edge.
REQ-037 flush=1 with v_in=1 and stall condition true -> stall=0, next cycle v_out=0, opcode=0010011.
REQ-038 wb_en=1, wb_rd=1, wb_data=32'hDEADBEEF same edge as accepting rs1=x1 -> rs1_val=old value without macro, 32'hDEADBEEF with DECODE_WB_BYPASS_EN; wb_rd=0 -> x0 reads 0.
REQ-039 IR_in=32'hFE000EE3 (beq x0,x0,-4) -> imm=32'hFFFFFFFC; IR_in=32'h0000007F -> illegal=1, v_out=1.
